ctrl_spi_master: RTL and testbench
==================================

// Module: ctrl_spi_master
// PURPOSE
//  SPI master behind the control-CPU register file (ctrl_regs). Receives the chip-select
//  register write (reg 0x14) and byte writes to the data register (reg 0x18).
//  Serialises each byte to the OSD, SD card and config SPI slaves, mode 0, MSB first.
//  Returns the received byte for read-back of reg 0x18.
// PARAMETERS
//  DW     8   transfer width, bits per byte
//  CSW    8   number of chip-select lines
//  DIVW   8   width of clock-divider field
// PORTS
//  clk          in   1     system clock
//  rst          in   1     synchronous reset, active high
//  cfg_div      in   DIVW  SCK half-period minus one, in clk cycles (D = cfg_div+1)
//  cs_we        in   1     write strobe for chip-select register
//  cs_dat       in   CSW   chip-select value; bit=1 selects slave (0x44 = OSD on, 0x40 = OSD off)
//  tx_we        in   1     write strobe for data register; starts a transfer
//  tx_dat       in   DW    byte to send
//  tx_ready     out  1     high when a new tx_we will be accepted
//  rx_dat       out  DW    last received byte; held until the next transfer completes
//  rx_valid     out  1     one-cycle pulse when rx_dat is updated
//  ovr          out  1     sticky: tx_we arrived while !tx_ready; cleared by cs_we
//  spi_cs_n     out  CSW   active-low chip selects
//  spi_sck      out  1     serial clock, idle low
//  spi_mosi     out  1     serial data out
//  spi_miso     in   1     serial data in
// BEHAVIOUR
//  - Reset values: spi_cs_n all 1, spi_sck 0, spi_mosi 1, rx_dat 0, rx_valid 0, tx_ready 1,
//    ovr 0, state IDLE, pending-CS flag clear. Reset mid-transfer aborts the transfer at the next edge.
//  - FSM states: IDLE, LO (SCK low phase), HI (SCK high phase), DONE.
//  - IDLE + tx_we (cycle 0): latch tx_dat into the shift register. Drive mosi=bit DW-1 and sck=0.
//    Set bit counter=0, tx_ready=0. Go to LO at cycle 1.
//  - LO: after D cycles, sck->1, sample spi_miso into the shift LSB, go to HI.
//  - HI: after D cycles, sck->0. If bit counter==DW-1, go to DONE; else increment the bit
//    counter, shift left, put the new MSB on mosi, and go to LO.
//  - DONE (single cycle): rx_dat<=shift register, rx_valid=1, tx_ready=1, mosi->1, then IDLE.
//  - Latency: tx_we at cycle 0 -> rx_valid at cycle 2*DW*D+1. The next tx_we may come in the same
//    cycle as rx_valid.
//  - tx_we while !tx_ready: the byte is dropped and ovr is set. The transfer in flight is unaffected.
//  - cs_we in IDLE: spi_cs_n <= ~cs_dat on the next edge.
//  - cs_we while busy: value held as pending and applied in the DONE cycle, so CS never changes
//    while SCK toggles. A later cs_we before DONE overwrites the pending value.
//  - cs_we and tx_we in the same IDLE cycle: CS is applied first (same edge), so the transfer
//    starts with the new CS.
//  - cfg_div is sampled at tx_we and held for the whole byte. Changing it mid-byte has no effect.
//  - Divider counter is DIVW bits and counts down from cfg_div. cfg_div=0 gives the fastest
//    rate, clk/2 on SCK. No wrap issue, because it reloads on every phase change.
// STRUCTURE
//  - Package ctrl_spi_pkg: state encoding (IDLE/LO/HI/DONE), register offsets
//    SPI_CS_ADR=0x14 and SPI_DAT_ADR=0x18, default DW/CSW/DIVW.
//  - Sub-module ctrl_spi_clkgen: loads D-1 on start and on each phase change, emits a
//    one-cycle `tick` at the end of each phase. The FSM and shift register stay in the top.
// TESTING
//  1 cfg_div=0, spi_miso looped to spi_mosi, tx 0xA5 -> 8 SCK pulses, mosi 1,0,1,0,0,1,0,1,
//    rx_valid at cycle 17, rx_dat=0xA5.
//  2 cfg_div=3, miso tied 0, tx 0xFF -> SCK high/low 4 clk each, rx_valid at cycle 65,
//    rx_dat=0x00.
//  3 cs_we 0x44 in IDLE -> spi_cs_n=0xBB next cycle. Then tx 0x1C and cs_we 0x40 at cycle 5 ->
//    spi_cs_n stays 0xBB until the DONE cycle, then becomes 0xBF.
//  4 tx 0x11, second tx_we 0x22 at cycle 3 -> only 0x11 shifted, ovr=1. Later cs_we -> ovr=0.
//  5 back-to-back: tx 0xAA, then 0xBB in the rx_valid cycle (cfg_div=0) -> second byte's first
//    SCK rise 1 cycle later, no idle gap, rx 0xAA then 0xBB with loopback.
//  6 rst asserted at cycle 6 of a transfer -> next edge all outputs at reset values.
//    A new tx 0x3C afterwards completes normally.

Source files
------------

// File: rtl/ctrl_spi_pkg.sv
// Shared definitions for the control-CPU SPI master: FSM encoding, register offsets, default sizes.
package ctrl_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  localparam logic [7:0] SPI_CS_ADR  = 8'h14;
  localparam logic [7:0] SPI_DAT_ADR = 8'h18;

  localparam int DW_DEF   = 8;
  localparam int CSW_DEF  = 8;
  localparam int DIVW_DEF = 8;

endpackage

// File: rtl/ctrl_spi_clkgen.sv
// SCK phase timer: reloads the held divider on start and on every phase end, ticks at each phase end.
module ctrl_spi_clkgen #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            run,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] cnt;

  // div_q keeps the rate fixed for the whole byte even if cfg_div moves
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (start) begin
      div_q <= div;
      cnt   <= div;
    end else if (run) begin
      if (cnt == '0) cnt <= div_q;
      else           cnt <= cnt - DIVW'(1);
    end
  end

  assign tick = run && (cnt == '0);

endmodule

// File: rtl/ctrl_spi_master.sv
// SPI master (mode 0, MSB first) behind the ctrl_regs chip-select and data registers.
// state | meaning
// IDLE  | no transfer, CS writes take effect immediately
// LO    | SCK low phase of the current bit
// HI    | SCK high phase of the current bit
// DONE  | one cycle: received byte presented, pending CS applied, ready for next byte
module ctrl_spi_master
  import ctrl_spi_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CSW  = CSW_DEF,
  parameter int DIVW = DIVW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIVW-1:0] cfg_div,
  input  logic            cs_we,
  input  logic [CSW-1:0]  cs_dat,
  input  logic            tx_we,
  input  logic [DW-1:0]   tx_dat,
  output logic            tx_ready,
  output logic [DW-1:0]   rx_dat,
  output logic            rx_valid,
  output logic            ovr,
  output logic [CSW-1:0]  spi_cs_n,
  output logic            spi_sck,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

  spi_state_e     state, state_nx;
  logic [DW-1:0]  shift_q;
  logic [BCW-1:0] bit_cnt;
  logic [CSW-1:0] cs_pend;
  logic           pend_v;
  logic           tick, start, busy, last_bit;

  assign busy     = (state == ST_LO) || (state == ST_HI);
  assign tx_ready = !busy;
  assign start    = tx_we && tx_ready;
  assign rx_valid = (state == ST_DONE);
  assign last_bit = (bit_cnt == LAST_BIT);

  ctrl_spi_clkgen #(.DIVW(DIVW)) u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .run   (busy),
    .div   (cfg_div),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LO;
      ST_LO:   if (tick) state_nx = ST_HI;
      ST_HI:   if (tick) state_nx = last_bit ? ST_DONE : ST_LO;
      ST_DONE: state_nx = start ? ST_LO : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // MISO enters the LSB on the rising edge; mosi is a separate register so the
  // outgoing bit stays stable through the high phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b1;
      rx_dat   <= '0;
      spi_cs_n <= '1;
      cs_pend  <= '1;
      pend_v   <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      ovr <= (ovr && !cs_we) || (tx_we && !tx_ready);
      if (cs_we && !busy) begin
        spi_cs_n <= ~cs_dat;
      end else if (cs_we) begin
        cs_pend <= ~cs_dat;
        pend_v  <= 1'b1;
      end
      if (start) begin
        shift_q  <= tx_dat;
        spi_mosi <= tx_dat[DW-1];
        bit_cnt  <= '0;
        spi_sck  <= 1'b0;
      end else if (tick && state == ST_LO) begin
        spi_sck <= 1'b1;
        shift_q <= {shift_q[DW-2:0], spi_miso};
      end else if (tick && state == ST_HI) begin
        spi_sck <= 1'b0;
        if (last_bit) begin
          rx_dat   <= shift_q;
          spi_mosi <= 1'b1;
          // SCK is parked from here on, so a held CS write can land safely
          if (cs_we) begin
            spi_cs_n <= ~cs_dat;
            pend_v   <= 1'b0;
          end else if (pend_v) begin
            spi_cs_n <= cs_pend;
            pend_v   <= 1'b0;
          end
        end else begin
          bit_cnt  <= bit_cnt + BCW'(1);
          spi_mosi <= shift_q[DW-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_spi_master.sv
// Self-checking bench for ctrl_spi_master: transaction-level model checked every cycle, plus directed literals.
module tb_ctrl_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_div;
  logic       cs_we;
  logic [7:0] cs_dat;
  logic       tx_we;
  logic [7:0] tx_dat;
  logic       tx_ready;
  logic [7:0] rx_dat;
  logic       rx_valid;
  logic       ovr;
  logic [7:0] spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       loop;
  logic       miso_drv;

  always #5 clk = ~clk;
  assign spi_miso = loop ? spi_mosi : miso_drv;

  ctrl_spi_master dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_div  (cfg_div),
    .cs_we    (cs_we),
    .cs_dat   (cs_dat),
    .tx_we    (tx_we),
    .tx_dat   (tx_dat),
    .tx_ready (tx_ready),
    .rx_dat   (rx_dat),
    .rx_valid (rx_valid),
    .ovr      (ovr),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: a byte accepted at cycle t0 with divisor D occupies
  // cycles t0+1 .. t0+16D (bit i spans 2D cycles, low half then high half),
  // and cycle t0+16D+1 is the completion cycle.
  bit         model_on = 0;
  bit         have = 0;
  int         t0 = 0;
  int         dm = 1;
  logic [7:0] bm;
  logic [7:0] rxacc;
  logic [7:0] rx_m;
  logic [7:0] cs_m;
  logic [7:0] pend_m;
  bit         pend_v_m;
  bit         ovr_m;

  function automatic bit model_ready(input int c);
    return !have || (c - t0) >= 16 * dm + 1;
  endfunction

  always @(posedge clk) begin
    int c, k;
    bit rdy;
    c = cyc;
    if (rst) begin
      have = 0; cs_m = 8'hFF; pend_v_m = 0; pend_m = 8'hFF; ovr_m = 0; rx_m = 8'h00;
      model_on = 1;
    end else begin
      k   = c - t0;
      rdy = model_ready(c);
      if (have && k >= 1 && k <= 16 * dm && ((k - 1) % (2 * dm)) == dm - 1)
        rxacc[7 - (k - 1) / (2 * dm)] = spi_miso;
      if (have && k == 16 * dm) rx_m = rxacc;
      if (cs_we) begin
        ovr_m = 0;
        if (rdy) cs_m = ~cs_dat;
        else begin pend_m = ~cs_dat; pend_v_m = 1; end
      end
      if (have && k == 16 * dm && pend_v_m) begin cs_m = pend_m; pend_v_m = 0; end
      if (tx_we) begin
        if (rdy) begin have = 1; t0 = c; dm = int'(cfg_div) + 1; bm = tx_dat; end
        else ovr_m = 1;
      end
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin
    int k;
    logic e_sck, e_mosi, e_rdy, e_rv;
    if (model_on) begin
      k = cyc - t0;
      e_sck = 1'b0; e_mosi = 1'b1; e_rdy = 1'b1; e_rv = 1'b0;
      if (have && k >= 1 && k <= 16 * dm) begin
        e_sck  = 1'(((k - 1) / dm) % 2);
        e_mosi = bm[7 - (k - 1) / (2 * dm)];
        e_rdy  = 1'b0;
      end else if (have && k == 16 * dm + 1) begin
        e_rv = 1'b1;
      end
      chk("sck", 32'(spi_sck), 32'(e_sck));
      chk("mosi", 32'(spi_mosi), 32'(e_mosi));
      chk("tx_ready", 32'(tx_ready), 32'(e_rdy));
      chk("rx_valid", 32'(rx_valid), 32'(e_rv));
      chk("rx_dat", 32'(rx_dat), 32'(rx_m));
      chk("cs_n", 32'(spi_cs_n), 32'(cs_m));
      chk("ovr", 32'(ovr), 32'(ovr_m));
    end
  end

  int         t_start, lat, pulses;
  logic [7:0] bits;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_dat = d; tx_we = 1'b1; t_start = cyc;
    step();
    tx_we = 1'b0;
  endtask

  task automatic wait_rx(input int limit);
    logic prev;
    bit got;
    prev = spi_sck; pulses = 0; bits = 8'h00; got = 0; lat = -1;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (spi_sck && !prev) begin pulses++; bits = {bits[6:0], spi_mosi}; end
      prev = spi_sck;
      if (rx_valid) begin got = 1; lat = cyc - t_start; end
    end
    if (!got) chk("rx_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; tx_we = 1'b0; cs_we = 1'b0; cs_dat = 8'h00; tx_dat = 8'h00;
    cfg_div = 8'd0; loop = 1'b0; miso_drv = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_cs_n", 32'(spi_cs_n), 32'hFF);
    chk("rst_sck", 32'(spi_sck), 32'h0);
    chk("rst_mosi", 32'(spi_mosi), 32'h1);
    chk("rst_ready", 32'(tx_ready), 32'h1);
    chk("rst_rx_dat", 32'(rx_dat), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);

    // 1: fastest rate, loopback
    cfg_div = 8'd0; loop = 1'b1;
    send(8'hA5);
    wait_rx(200);
    chk("t1_lat", 32'(lat), 32'd17);
    chk("t1_rx", 32'(rx_dat), 32'hA5);
    chk("t1_pulses", 32'(pulses), 32'd8);
    chk("t1_mosi_bits", 32'(bits), 32'hA5);
    step();

    // 2: D=4, miso low
    cfg_div = 8'd3; loop = 1'b0; miso_drv = 1'b0;
    send(8'hFF);
    cfg_div = 8'd0;
    wait_rx(500);
    chk("t2_lat", 32'(lat), 32'd65);
    chk("t2_rx", 32'(rx_dat), 32'h00);
    chk("t2_pulses", 32'(pulses), 32'd8);
    step();

    // 3: CS immediate in IDLE, deferred while busy
    cs_dat = 8'h44; cs_we = 1'b1;
    step();
    cs_we = 1'b0;
    chk("t3_cs_idle", 32'(spi_cs_n), 32'hBB);
    cfg_div = 8'd1; loop = 1'b1;
    send(8'h1C);
    repeat (4) step();
    cs_dat = 8'h40; cs_we = 1'b1;
    step();
    cs_we = 1'b0;
    chk("t3_cs_held", 32'(spi_cs_n), 32'hBB);
    wait_rx(500);
    chk("t3_cs_done", 32'(spi_cs_n), 32'hBF);
    chk("t3_rx", 32'(rx_dat), 32'h1C);
    step();

    // 4: overrun while busy
    send(8'h11);
    repeat (2) step();
    tx_dat = 8'h22; tx_we = 1'b1;
    step();
    tx_we = 1'b0;
    chk("t4_ovr_set", 32'(ovr), 32'h1);
    wait_rx(500);
    chk("t4_lat", 32'(lat), 32'd33);
    chk("t4_rx", 32'(rx_dat), 32'h11);
    step();
    cs_dat = 8'h40; cs_we = 1'b1;
    step();
    cs_we = 1'b0;
    chk("t4_ovr_clr", 32'(ovr), 32'h0);

    // 5: back-to-back, second write in the rx_valid cycle
    cfg_div = 8'd0;
    send(8'hAA);
    wait_rx(200);
    chk("t5_rx1", 32'(rx_dat), 32'hAA);
    tx_dat = 8'hBB; tx_we = 1'b1; t_start = cyc;
    @(posedge clk); #1;
    tx_we = 1'b0;
    wait_rx(200);
    chk("t5_lat2", 32'(lat), 32'd17);
    chk("t5_rx2", 32'(rx_dat), 32'hBB);
    step();

    // 6: reset mid-transfer (with ovr set first), then a clean transfer
    send(8'h5A);
    repeat (2) step();
    tx_dat = 8'h77; tx_we = 1'b1;
    step();
    tx_we = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("t6_cs_n", 32'(spi_cs_n), 32'hFF);
    chk("t6_sck", 32'(spi_sck), 32'h0);
    chk("t6_mosi", 32'(spi_mosi), 32'h1);
    chk("t6_ready", 32'(tx_ready), 32'h1);
    chk("t6_rx_valid", 32'(rx_valid), 32'h0);
    chk("t6_rx_dat", 32'(rx_dat), 32'h0);
    chk("t6_ovr", 32'(ovr), 32'h0);
    rst = 1'b0;
    step();
    send(8'h3C);
    wait_rx(200);
    chk("t6_lat", 32'(lat), 32'd17);
    chk("t6_rx", 32'(rx_dat), 32'h3C);
    step();

    // Random traffic against the model
    loop = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cfg_div  = 8'($urandom_range(0, 3));
      tx_we    = ($urandom_range(0, 7) == 0);
      tx_dat   = 8'($urandom);
      cs_we    = ($urandom_range(0, 15) == 0);
      cs_dat   = 8'($urandom);
      miso_drv = 1'($urandom);
      rst      = ($urandom_range(0, 499) == 0);
      step();
    end
    tx_we = 1'b0; cs_we = 1'b0; rst = 1'b0;
    repeat (80) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
